counter_scan_display: RTL

COUNTER_SCAN_DISPLAY -- requirements
Module: counter_scan_display

---
 rtl/counter_scan_display.sv | 121 ++++++++++++
 1 files changed

// File: rtl/counter_scan_display.sv
// Debounced push-button up/down counter with a multiplexed nibble display scan.
// Raw inputs are synchronized, btn is debounced, and each accepted press steps the counter once.
module counter_scan_display #(
  parameter int               WIDTH     = 32,
  parameter int               SCAN_DIV  = 262144,
  parameter int               DB_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] LOAD_VAL  = 'h1F,
  parameter bit               SATURATE  = 1'b0,
  localparam int              ND        = WIDTH / 4,
  localparam int              AW        = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             up,
  input  logic             load,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       d,
  output logic [AW-1:0]    an,
  output logic             ovf
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [WIDTH-1:0] VMAX = {WIDTH{1'b1}};

  logic [1:0]    btn_sync, up_sync, load_sync;
  logic          btn_s, up_s, load_s;
  logic [DW-1:0] db_cnt;
  logic          db_level, db_level_q;
  logic          step;
  logic [SW-1:0] scan_cnt;
  logic [3:0]    nib [ND];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync  <= '0;
      up_sync   <= '0;
      load_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[0], btn};
      up_sync   <= {up_sync[0], up};
      load_sync <= {load_sync[0], load};
    end
  end

  assign btn_s  = btn_sync[1];
  assign up_s   = up_sync[1];
  assign load_s = load_sync[1];

  // The level only follows btn after it has differed for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
    end else begin
      db_level_q <= db_level;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign step = db_level & ~db_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (step) begin
        if (load_s) begin
          value <= LOAD_VAL;
        end else if (up_s) begin
          if (value == VMAX) begin
            ovf <= 1'b1;
            if (!SATURATE) value <= '0;
          end else begin
            value <= value + WIDTH'(1);
          end
        end else begin
          if (value == '0) begin
            ovf <= 1'b1;
            if (!SATURATE) value <= VMAX;
          end else begin
            value <= value - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      an       <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      an       <= (an == AW'(ND - 1)) ? '0 : an + AW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  for (genvar i = 0; i < ND; i++) begin : g_nib
    assign nib[i] = value[4*i +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d <= '0;
    else     d <= nib[an];
  end

endmodule
